// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO fed by valid/ready, serialised as
// start / 8 data LSB-first / optional parity / 1-2 stop bits on baud_tick.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   baud_tick        one-clock strobe marking each bit boundary
//   i_data, i_valid  byte to queue and its valid flag
//   o_ready          FIFO not full (push accepted when i_valid && o_ready)
//   o_out            registered serial line, idle high
//   o_busy           registered, high while a frame is in progress
//   o_fifo_count     bytes currently buffered
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          baud_tick,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_out,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        r_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit;
    logic          r_par;
    logic          r_stop;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_last_stop;
    logic [7:0]    w_head;

    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_push      = i_valid && !w_full;
    assign w_last_stop = (STOP_BITS == 1) || r_stop;
    assign w_head      = r_mem[r_rptr];

    // A byte leaves the FIFO only on a tick that starts a new frame.
    assign w_pop = baud_tick && !w_empty &&
                   ((r_state == S_IDLE) ||
                    (r_state == S_STOP && w_last_stop));

    assign o_ready      = !w_full;
    assign o_fifo_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            o_out   <= 1'b1;
            o_busy  <= 1'b0;
            r_shift <= '0;
            r_bit   <= '0;
            r_par   <= 1'b0;
            r_stop  <= 1'b0;
        end else if (baud_tick) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= (^w_head) ^ (PARITY_ODD != 0);
                        o_out   <= 1'b0;
                        o_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    o_out   <= r_shift[0];
                    r_shift <= {1'b0, r_shift[7:1]};
                    r_bit   <= '0;
                    r_state <= S_DATA;
                end
                S_DATA: begin
                    // r_bit is the index of the bit currently on the line.
                    if (r_bit == 3'd7) begin
                        r_stop <= 1'b0;
                        if (PARITY_EN != 0) begin
                            o_out   <= r_par;
                            r_state <= S_PARITY;
                        end else begin
                            o_out   <= 1'b1;
                            r_state <= S_STOP;
                        end
                    end else begin
                        o_out   <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                    end
                end
                S_PARITY: begin
                    o_out   <= 1'b1;
                    r_stop  <= 1'b0;
                    r_state <= S_STOP;
                end
                S_STOP: begin
                    if (w_last_stop) begin
                        if (w_pop) begin
                            // Next frame starts with no idle gap.
                            r_shift <= w_head;
                            r_par   <= (^w_head) ^ (PARITY_ODD != 0);
                            o_out   <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            o_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_stop <= 1'b1;
                    end
                end
                default: begin
                    o_out   <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameter variants share the clock,
// reset and baud tick; frames are sampled mid-bit and compared to constants.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [3:0] v;
    logic [7:0] d [4];
    wire  [3:0] w_out;
    wire  [3:0] w_busy;
    wire  [3:0] w_rdy;
    wire  [2:0] w_cnt [4];

    int n_vec = 0;
    int n_err = 0;
    int tcnt  = 0;
    int bc [4];
    logic [47:0] fr;
    int fc [48];
    int lo;

    uart_tx #(.FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .baud_tick(tick),
        .i_data(d[0]), .i_valid(v[0]), .o_ready(w_rdy[0]),
        .o_out(w_out[0]), .o_busy(w_busy[0]), .o_fifo_count(w_cnt[0])
    );
    uart_tx #(.FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .baud_tick(tick),
        .i_data(d[1]), .i_valid(v[1]), .o_ready(w_rdy[1]),
        .o_out(w_out[1]), .o_busy(w_busy[1]), .o_fifo_count(w_cnt[1])
    );
    uart_tx #(.FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .baud_tick(tick),
        .i_data(d[2]), .i_valid(v[2]), .o_ready(w_rdy[2]),
        .o_out(w_out[2]), .o_busy(w_busy[2]), .o_fifo_count(w_cnt[2])
    );
    uart_tx #(.FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .baud_tick(tick),
        .i_data(d[3]), .i_valid(v[3]), .o_ready(w_rdy[3]),
        .o_out(w_out[3]), .o_busy(w_busy[3]), .o_fifo_count(w_cnt[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick on every 16th rising edge; updated just after the edge.
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt + 1) % 16;
            tick = (tcnt == 15);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int s = 0; s < 4; s++) begin
                if (w_busy[s]) bc[s]++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push1(input int s, input logic [7:0] b);
        v[s] = 1'b1;
        d[s] = b;
        @(negedge clk);
        v[s] = 1'b0;
    endtask

    task automatic sync_tick();
        do @(negedge clk); while (tcnt != 0);
    endtask

    task automatic wait_start(input int s, input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (w_out[s] !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_start"}, 64'(t < 300), 64'd1);
        v[s] = 1'b0;
    endtask

    task automatic cap(input int s, input int nb, input string tag);
        wait_start(s, tag);
        repeat (8) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            fr[i] = w_out[s];
            fc[i] = int'(w_cnt[s]);
            if (i < nb - 1) repeat (16) @(negedge clk);
        end
    endtask

    task automatic idle_watch(input int s);
        lo = 0;
        repeat (64) begin
            @(negedge clk);
            if (w_out[s] !== 1'b1) lo++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v     = '0;
        for (int s = 0; s < 4; s++) begin
            d[s]  = 8'h00;
            bc[s] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_out",   64'(w_out[0]),  64'd1);
        check("rst_busy",  64'(w_busy[0]), 64'd0);
        check("rst_cnt",   64'(w_cnt[0]),  64'd0);
        check("rst_ready", 64'(w_rdy[0]),  64'd1);
        check("rst_out3",  64'(w_out[3]),  64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte, default framing.
        bc[0] = 0;
        push1(0, 8'h41);
        cap(0, 10, "t1");
        check("t1_frame", 64'(fr[9:0]), 64'(10'h282));
        repeat (24) @(negedge clk);
        check("t1_busy_clks", 64'(bc[0]), 64'd160);
        check("t1_idle_out",  64'(w_out[0]), 64'd1);
        check("t1_idle_busy", 64'(w_busy[0]), 64'd0);

        // Fill FIFO, then offer 0x99 while full across the first pop.
        sync_tick();
        push1(0, 8'h55);
        push1(0, 8'hAA);
        push1(0, 8'h0F);
        v[0] = 1'b1;
        d[0] = 8'hF0;
        @(negedge clk);
        check("t2_ready_full", 64'(w_rdy[0]), 64'd0);
        check("t2_cnt_full",   64'(w_cnt[0]), 64'd4);
        d[0] = 8'h99;
        cap(0, 40, "t2");
        check("t2_f0", 64'(fr[9:0]),   64'({1'b1, 8'h55, 1'b0}));
        check("t2_f1", 64'(fr[19:10]), 64'({1'b1, 8'hAA, 1'b0}));
        check("t2_f2", 64'(fr[29:20]), 64'({1'b1, 8'h0F, 1'b0}));
        check("t2_f3", 64'(fr[39:30]), 64'({1'b1, 8'hF0, 1'b0}));
        check("t2_cnt0", 64'(fc[0]),  64'd3);
        check("t2_cnt1", 64'(fc[10]), 64'd2);
        check("t2_cnt2", 64'(fc[20]), 64'd1);
        check("t2_cnt3", 64'(fc[30]), 64'd0);
        idle_watch(0);
        check("t2_no_99",  64'(lo), 64'd0);
        check("t2_cnt_end", 64'(w_cnt[0]), 64'd0);
        check("t2_busy_end", 64'(w_busy[0]), 64'd0);

        // Even parity, 0x07.
        bc[1] = 0;
        push1(1, 8'h07);
        cap(1, 12, "t3e");
        check("t3e_par",   64'(fr[9]), 64'd1);
        check("t3e_frame", 64'(fr[11:0]), 64'({3'b111, 8'h07, 1'b0}));
        repeat (24) @(negedge clk);
        check("t3e_busy_clks", 64'(bc[1]), 64'd176);

        // Odd parity, 0x03.
        bc[2] = 0;
        push1(2, 8'h03);
        cap(2, 12, "t3o");
        check("t3o_par",   64'(fr[9]), 64'd1);
        check("t3o_frame", 64'(fr[11:0]), 64'({3'b111, 8'h03, 1'b0}));
        repeat (24) @(negedge clk);
        check("t3o_busy_clks", 64'(bc[2]), 64'd176);

        // Two stop bits between back-to-back frames.
        sync_tick();
        push1(3, 8'h00);
        push1(3, 8'h01);
        cap(3, 22, "t4");
        check("t4_cnt", 64'(fc[0]), 64'd1);
        check("t4_frames", 64'(fr[21:0]),
              64'({2'b11, 8'h01, 1'b0, 2'b11, 8'h00, 1'b0}));

        // Asynchronous reset during data bit 3 with two bytes queued.
        sync_tick();
        push1(0, 8'h00);
        push1(0, 8'h11);
        push1(0, 8'h22);
        wait_start(0, "t5");
        repeat (72) @(negedge clk);
        check("t5_pre_line", 64'(w_out[0]),  64'd0);
        check("t5_pre_busy", 64'(w_busy[0]), 64'd1);
        check("t5_pre_cnt",  64'(w_cnt[0]),  64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out",   64'(w_out[0]),  64'd1);
        check("t5_rst_busy",  64'(w_busy[0]), 64'd0);
        check("t5_rst_cnt",   64'(w_cnt[0]),  64'd0);
        check("t5_rst_ready", 64'(w_rdy[0]),  64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_watch(0);
        check("t5_idle_line", 64'(lo), 64'd0);
        check("t5_idle_busy", 64'(w_busy[0]), 64'd0);
        push1(0, 8'h5A);
        cap(0, 10, "t5b");
        check("t5b_frame", 64'(fr[9:0]), 64'({1'b1, 8'h5A, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
